am_lock_multimode: RTL and testbench

Parametrised alignment-marker (AM) lock block for one PCS lane, placed between block_sync and the deskew/lane-reorder stages. It matches incoming 66-bit blocks against a runtime-programmable AM table, runs the AM lock state machine with programmable thresholds, and replaces locked AMs with idle control blocks. It also computes BIP3 per lane, checks it against the received BIP3, and verifies the BIP7 complement. The block is the successor to the fixed-table lock module: the table, compare mask, period and check mode are register-file driven.

---
 rtl/am_lock_multimode.sv | 257 +++++++++++++++++++++++++
 tb/tb_am_lock_multimode.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_lock_multimode.sv
// Alignment-marker lock for one PCS lane: programmable AM table match, lock FSM, AM-to-idle replacement, BIP3/BIP7 checks.
// Latency: o_data/o_valid/o_start_of_lane 1 cycle; lock status, lane id and pulses update on the edge consuming the deciding block.
// Backpressure: none; one block consumed per i_valid, i_rf_enable low freezes all state and forces o_valid low.
module am_lock_multimode #(
    parameter int NB_CODED_BLOCK    = 66,
    parameter int N_ALIGNER         = 20,
    parameter int NB_LANE_ID        = $clog2(N_ALIGNER),
    parameter int NB_AM             = 48,
    parameter int NB_AM_PERIOD      = 16,
    parameter int NB_VAL_AM         = 5,
    parameter int NB_INV_AM         = 3,
    parameter int NB_ERROR_COUNTER  = 32,
    parameter int NB_RESYNC_COUNTER = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_rf_enable,
    input  logic                          i_valid,
    input  logic                          i_block_lock,
    input  logic [NB_CODED_BLOCK-1:0]     i_data,
    input  logic [N_ALIGNER*NB_AM-1:0]    i_rf_am_table,
    input  logic [NB_AM-1:0]              i_rf_compare_mask,
    input  logic [NB_VAL_AM-1:0]          i_rf_valid_am_thr,
    input  logic [NB_INV_AM-1:0]          i_rf_invalid_am_thr,
    input  logic [NB_AM_PERIOD-1:0]       i_rf_am_period,
    input  logic                          i_rf_bip7_check,
    output logic [NB_CODED_BLOCK-1:0]     o_data,
    output logic                          o_valid,
    output logic                          o_start_of_lane,
    output logic [NB_LANE_ID-1:0]         o_lane_id,
    output logic                          o_am_lock,
    output logic                          o_resync,
    output logic                          o_bip_error,
    output logic [NB_ERROR_COUNTER-1:0]   o_error_counter,
    output logic [NB_RESYNC_COUNTER-1:0]  o_resync_counter
);

    localparam logic [NB_CODED_BLOCK-1:0] IDLE_BLOCK = {2'b10, 8'h1E, {(NB_CODED_BLOCK-10){1'b0}}};

    typedef enum logic [1:0] {LOCK_INIT, FIND_FIRST, COUNT, LOCKED} state_t;

    state_t                   state_q, state_d;
    logic [NB_VAL_AM-1:0]     good_q, good_d;
    logic [NB_INV_AM-1:0]     bad_q, bad_d;
    logic [NB_AM_PERIOD-1:0]  period_cnt_q, period_cnt_d;
    logic [NB_LANE_ID-1:0]    lane_d;
    logic                     lock_d;
    logic [7:0]               bip_acc_q, bip_acc_d;

    logic [NB_AM-1:0]         am_value;
    logic [7:0]               bip3_rx;
    logic [7:0]               bip7_rx;
    logic                     sync_ok;
    logic [N_ALIGNER-1:0]     match;
    logic                     hit;
    logic [NB_LANE_ID-1:0]    hit_id;
    logic [NB_AM-1:0]         expected_entry;
    logic                     am_good;
    logic [NB_VAL_AM-1:0]     val_thr_eff;
    logic [NB_INV_AM-1:0]     inv_thr_eff;
    logic                     resync;
    logic                     sol;
    logic                     am_pos;
    logic                     bip_check;
    logic                     bip_mismatch;
    logic [7:0]               bip_blk;

    // BIP3 contribution of one 66-bit block: payload bits interleaved over 8 lanes, sync bits fold into lanes 3 and 4
    function automatic logic [7:0] bip_contrib(input logic [NB_CODED_BLOCK-1:0] blk);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++) begin
                r[j] = r[j] ^ blk[63 - j - 8*k];
            end
        end
        r[3] = r[3] ^ blk[65];
        r[4] = r[4] ^ blk[64];
        return r;
    endfunction

    assign am_value    = {i_data[63:40], i_data[31:8]};
    assign bip3_rx     = i_data[39:32];
    assign bip7_rx     = i_data[7:0];
    assign sync_ok     = (i_data[65:64] == 2'b10);
    assign val_thr_eff = (i_rf_valid_am_thr < NB_VAL_AM'(2)) ? NB_VAL_AM'(1) : i_rf_valid_am_thr;
    assign inv_thr_eff = (i_rf_invalid_am_thr < NB_INV_AM'(2)) ? NB_INV_AM'(1) : i_rf_invalid_am_thr;

    // Match the block against every table entry under the mask; a hit needs exactly one matching entry
    always_comb begin
        match  = '0;
        hit_id = '0;
        for (int k = 0; k < N_ALIGNER; k++) begin
            match[k] = (((am_value ^ i_rf_am_table[k*NB_AM +: NB_AM]) & i_rf_compare_mask) == '0);
            if (match[k]) begin
                hit_id = NB_LANE_ID'(k);
            end
        end
        hit = sync_ok && (match != '0) && ((match & (match - N_ALIGNER'(1))) == '0);
    end

    // Once tracking, only the latched entry is compared; BIP7 must be the complement of BIP3 when enabled
    always_comb begin
        expected_entry = '0;
        for (int k = 0; k < N_ALIGNER; k++) begin
            if (o_lane_id == NB_LANE_ID'(k)) begin
                expected_entry = i_rf_am_table[k*NB_AM +: NB_AM];
            end
        end
        am_good = sync_ok
               && (((am_value ^ expected_entry) & i_rf_compare_mask) == '0)
               && (!i_rf_bip7_check || (bip7_rx == ~bip3_rx));
    end

    // Lock FSM next state; block_lock loss takes priority over any AM decision in the same cycle
    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        bad_d        = bad_q;
        period_cnt_d = period_cnt_q;
        lane_d       = o_lane_id;
        lock_d       = o_am_lock;
        resync       = 1'b0;
        sol          = 1'b0;
        am_pos       = 1'b0;
        bip_check    = 1'b0;
        if (i_rf_enable) begin
            if (!i_block_lock) begin
                state_d      = LOCK_INIT;
                good_d       = '0;
                bad_d        = '0;
                period_cnt_d = '0;
                if (o_am_lock) begin
                    lock_d = 1'b0;
                    resync = 1'b1;
                end
            end else if (i_valid) begin
                case (state_q)
                    LOCK_INIT: begin
                        state_d      = FIND_FIRST;
                        good_d       = '0;
                        bad_d        = '0;
                        period_cnt_d = '0;
                    end
                    FIND_FIRST: begin
                        if (hit) begin
                            lane_d       = hit_id;
                            good_d       = NB_VAL_AM'(1);
                            bad_d        = '0;
                            period_cnt_d = i_rf_am_period - NB_AM_PERIOD'(1);
                            state_d      = COUNT;
                            sol          = 1'b1;
                            am_pos       = 1'b1;
                        end
                    end
                    COUNT: begin
                        if (period_cnt_q == '0) begin
                            am_pos       = 1'b1;
                            period_cnt_d = i_rf_am_period - NB_AM_PERIOD'(1);
                            if (am_good) begin
                                good_d = good_q + NB_VAL_AM'(1);
                                if (good_d >= val_thr_eff) begin
                                    lock_d  = 1'b1;
                                    bad_d   = '0;
                                    state_d = LOCKED;
                                end
                            end else begin
                                resync  = 1'b1;
                                state_d = FIND_FIRST;
                            end
                        end else begin
                            period_cnt_d = period_cnt_q - NB_AM_PERIOD'(1);
                        end
                    end
                    LOCKED: begin
                        if (period_cnt_q == '0) begin
                            am_pos       = 1'b1;
                            sol          = 1'b1;
                            bip_check    = o_am_lock;
                            period_cnt_d = i_rf_am_period - NB_AM_PERIOD'(1);
                            if (am_good) begin
                                bad_d = '0;
                            end else begin
                                bad_d = bad_q + NB_INV_AM'(1);
                                if (bad_d >= inv_thr_eff) begin
                                    resync  = 1'b1;
                                    lock_d  = 1'b0;
                                    state_d = FIND_FIRST;
                                end
                            end
                        end else begin
                            period_cnt_d = period_cnt_q - NB_AM_PERIOD'(1);
                        end
                    end
                    default: state_d = LOCK_INIT;
                endcase
            end
        end
    end

    // BIP3 accumulator restarts at every AM boundary so the window always spans exactly one period
    always_comb begin
        bip_blk      = bip_contrib(i_data);
        bip_mismatch = bip_check && (bip_acc_q != bip3_rx);
        bip_acc_d    = bip_acc_q;
        if (i_rf_enable && i_valid) begin
            bip_acc_d = am_pos ? bip_blk : (bip_acc_q ^ bip_blk);
        end
    end

    // State, status and output registers; disabled cycles hold everything and squash strobes
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q          <= LOCK_INIT;
            good_q           <= '0;
            bad_q            <= '0;
            period_cnt_q     <= '0;
            bip_acc_q        <= '0;
            o_data           <= '0;
            o_valid          <= 1'b0;
            o_start_of_lane  <= 1'b0;
            o_lane_id        <= '0;
            o_am_lock        <= 1'b0;
            o_resync         <= 1'b0;
            o_bip_error      <= 1'b0;
            o_error_counter  <= '0;
            o_resync_counter <= '0;
        end else if (i_rf_enable) begin
            state_q         <= state_d;
            good_q          <= good_d;
            bad_q           <= bad_d;
            period_cnt_q    <= period_cnt_d;
            bip_acc_q       <= bip_acc_d;
            o_data          <= sol ? IDLE_BLOCK : i_data;
            o_valid         <= i_valid;
            o_start_of_lane <= sol;
            o_lane_id       <= lane_d;
            o_am_lock       <= lock_d;
            o_resync        <= resync;
            o_bip_error     <= bip_mismatch;
            if (resync) begin
                o_error_counter <= '0;
            end else if (bip_mismatch && !(&o_error_counter)) begin
                o_error_counter <= o_error_counter + NB_ERROR_COUNTER'(1);
            end
            if (resync && !(&o_resync_counter)) begin
                o_resync_counter <= o_resync_counter + NB_RESYNC_COUNTER'(1);
            end
        end else begin
            o_valid         <= 1'b0;
            o_start_of_lane <= 1'b0;
            o_resync        <= 1'b0;
            o_bip_error     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_am_lock_multimode.sv
// Randomized bench for am_lock_multimode: a transmitter model builds a lane AM stream with a true BIP3,
// a block-index based reference predicts every output beat, and directed phases cover lock, unlock, BIP and reset cases.
module tb_am_lock_multimode;

    localparam int NA   = 20;
    localparam int LANE = 5;
    localparam int P    = 16;
    localparam logic [65:0] IDLE = {2'b10, 8'h1E, 56'h0};

    logic            i_clock = 1'b0;
    logic            i_reset;
    logic            i_rf_enable;
    logic            i_valid;
    logic            i_block_lock;
    logic [65:0]     i_data;
    logic [NA*48-1:0] i_rf_am_table;
    logic [47:0]     i_rf_compare_mask;
    logic [4:0]      i_rf_valid_am_thr;
    logic [2:0]      i_rf_invalid_am_thr;
    logic [15:0]     i_rf_am_period;
    logic            i_rf_bip7_check;
    logic [65:0]     o_data;
    logic            o_valid;
    logic            o_start_of_lane;
    logic [4:0]      o_lane_id;
    logic            o_am_lock;
    logic            o_resync;
    logic            o_bip_error;
    logic [31:0]     o_error_counter;
    logic [7:0]      o_resync_counter;

    always #5 i_clock = ~i_clock;

    am_lock_multimode dut (
        .i_clock             (i_clock),
        .i_reset             (i_reset),
        .i_rf_enable         (i_rf_enable),
        .i_valid             (i_valid),
        .i_block_lock        (i_block_lock),
        .i_data              (i_data),
        .i_rf_am_table       (i_rf_am_table),
        .i_rf_compare_mask   (i_rf_compare_mask),
        .i_rf_valid_am_thr   (i_rf_valid_am_thr),
        .i_rf_invalid_am_thr (i_rf_invalid_am_thr),
        .i_rf_am_period      (i_rf_am_period),
        .i_rf_bip7_check     (i_rf_bip7_check),
        .o_data              (o_data),
        .o_valid             (o_valid),
        .o_start_of_lane     (o_start_of_lane),
        .o_lane_id           (o_lane_id),
        .o_am_lock           (o_am_lock),
        .o_resync            (o_resync),
        .o_bip_error         (o_bip_error),
        .o_error_counter     (o_error_counter),
        .o_resync_counter    (o_resync_counter)
    );

    int n_chk;
    int n_pass;

    logic [47:0] tbl [NA];

    // transmitter state
    int          tx_pos;
    logic [7:0]  tx_acc;
    int          tx_bad_am;
    int          tx_bad_bip7;
    bit          tx_flip;

    // reference state: progress expressed as absolute valid-block indices
    bit          m_armed;
    bit          m_tracking;
    bit          m_locked;
    int          m_lane;
    int          m_good;
    int          m_bad;
    longint      m_n;
    longint      m_next;
    logic [7:0]  m_acc;
    longint      m_err;
    longint      m_rsc;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // BIP3 written in transmitted-bit order: bits 0/1 are the sync header, payload bit t lands on lane (t-2) mod 8
    function automatic logic [7:0] bip_ref(input logic [65:0] b);
        logic [7:0] r;
        int j;
        r = '0;
        for (int t = 0; t < 66; t++) begin
            j = (t < 2) ? t + 3 : (t - 2) % 8;
            r[j] = r[j] ^ b[65 - t];
        end
        return r;
    endfunction

    function automatic int eff(input int t);
        return (t < 2) ? 1 : t;
    endfunction

    function automatic bit am_ok(input logic [65:0] b, input int lane);
        logic [47:0] v;
        logic [7:0]  b3;
        v  = {b[63:40], b[31:8]};
        b3 = ~b[39:32];
        if (b[65:64] != 2'b10) return 1'b0;
        if (((v ^ tbl[lane]) & i_rf_compare_mask) != 48'h0) return 1'b0;
        if (i_rf_bip7_check && (b[7:0] != b3)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit unique_hit(input logic [65:0] b, output int id);
        int cnt;
        cnt = 0;
        id  = 0;
        for (int k = 0; k < NA; k++) begin
            if (b[65:64] == 2'b10 && ((({b[63:40], b[31:8]}) ^ tbl[k]) & i_rf_compare_mask) == 48'h0) begin
                cnt++;
                id = k;
            end
        end
        return cnt == 1;
    endfunction

    task automatic pack_table();
        for (int k = 0; k < NA; k++) i_rf_am_table[k*48 +: 48] = tbl[k];
    endtask

    task automatic model_reset();
        m_armed = 0; m_tracking = 0; m_locked = 0;
        m_lane = 0; m_good = 0; m_bad = 0;
        m_n = 0; m_next = 0; m_acc = '0; m_err = 0; m_rsc = 0;
    endtask

    // Apply one cycle of inputs, then predict and compare every output
    task automatic beat(input bit en, input bit vld, input bit bl, input logic [65:0] blk);
        bit e_sol, e_rs, e_be, am, good;
        int id;
        i_rf_enable  = en;
        i_valid      = vld;
        i_block_lock = bl;
        i_data       = blk;
        @(posedge i_clock);
        #1;
        e_sol = 0; e_rs = 0; e_be = 0; am = 0;
        if (en) begin
            if (!bl) begin
                if (m_locked) e_rs = 1;
                m_locked = 0; m_tracking = 0; m_armed = 0;
            end else if (vld) begin
                if (!m_armed) begin
                    m_armed = 1;
                end else if (!m_tracking) begin
                    if (unique_hit(blk, id)) begin
                        m_lane = id; m_tracking = 1; m_good = 1; m_bad = 0;
                        m_next = m_n + i_rf_am_period; e_sol = 1; am = 1;
                    end
                end else if (m_n == m_next) begin
                    am     = 1;
                    m_next = m_n + i_rf_am_period;
                    good   = am_ok(blk, m_lane);
                    if (m_locked) begin
                        e_sol = 1;
                        e_be  = (m_acc != blk[39:32]);
                        if (good) m_bad = 0;
                        else begin
                            m_bad++;
                            if (m_bad >= eff(i_rf_invalid_am_thr)) begin
                                e_rs = 1; m_locked = 0; m_tracking = 0;
                            end
                        end
                    end else if (good) begin
                        m_good++;
                        if (m_good >= eff(i_rf_valid_am_thr)) begin
                            m_locked = 1; m_bad = 0;
                        end
                    end else begin
                        e_rs = 1; m_tracking = 0;
                    end
                end
            end
            if (vld) begin
                m_acc = am ? bip_ref(blk) : (m_acc ^ bip_ref(blk));
                m_n++;
            end
            if (e_rs) begin
                m_err = 0;
                if (m_rsc < 255) m_rsc++;
            end else if (e_be && m_err < 64'hFFFF_FFFF) begin
                m_err++;
            end
            chk("data", o_data, e_sol ? IDLE : blk);
        end
        chk("valid", o_valid, en & vld);
        chk("start_of_lane", o_start_of_lane, e_sol);
        chk("am_lock", o_am_lock, m_locked);
        chk("lane_id", o_lane_id, m_lane);
        chk("resync", o_resync, e_rs);
        chk("bip_error", o_bip_error, e_be);
        chk("error_counter", o_error_counter, 66'(m_err));
        chk("resync_counter", o_resync_counter, 66'(m_rsc));
    endtask

    // Next block of the lane stream; AM carries BIP3 of the previous period and its complement as BIP7
    task automatic gen(output logic [65:0] blk);
        logic [47:0] am;
        if (tx_pos == 0) begin
            am  = tbl[LANE];
            blk = {2'b10, am[47:24], tx_acc, am[23:0], ~tx_acc};
            if (tx_bad_am > 0) begin
                blk[40 + $urandom_range(0, 23)] ^= 1'b1;
                tx_bad_am--;
            end
            if (tx_bad_bip7 > 0) begin
                blk[7:0] = tx_acc;
                tx_bad_bip7--;
            end
            tx_acc = bip_ref(blk);
        end else begin
            blk    = {2'b01, $urandom, $urandom};
            tx_acc = tx_acc ^ bip_ref(blk);
            if (tx_flip) begin
                blk[$urandom_range(0, 63)] ^= 1'b1;
                tx_flip = 0;
            end
        end
        tx_pos = (tx_pos + 1) % P;
    endtask

    task automatic send(input int n, input bit bl);
        logic [65:0] blk;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) beat(1, 0, 1, {2'($urandom), $urandom, $urandom});
            gen(blk);
            beat(1, 1, bl, blk);
        end
    endtask

    task automatic check_all_zero(input string ph);
        chk({ph, "_data"}, o_data, 0);
        chk({ph, "_valid"}, o_valid, 0);
        chk({ph, "_sol"}, o_start_of_lane, 0);
        chk({ph, "_lane"}, o_lane_id, 0);
        chk({ph, "_lock"}, o_am_lock, 0);
        chk({ph, "_resync"}, o_resync, 0);
        chk({ph, "_bip"}, o_bip_error, 0);
        chk({ph, "_errcnt"}, o_error_counter, 0);
        chk({ph, "_rscnt"}, o_resync_counter, 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        i_reset = 1'b0;
        i_rf_enable = 1'b0;
        i_valid = 1'b0;
        i_block_lock = 1'b0;
        i_data = '0;
        i_rf_am_period = 16'(P);
        i_rf_valid_am_thr = 5'd2;
        i_rf_invalid_am_thr = 3'd3;
        i_rf_bip7_check = 1'b0;
        i_rf_compare_mask = '1;
        for (int k = 0; k < NA; k++) tbl[k] = 48'({$urandom, $urandom});
        pack_table();
        model_reset();
        tx_pos = 5; tx_acc = '0; tx_bad_am = 0; tx_bad_bip7 = 0; tx_flip = 0;

        repeat (3) @(posedge i_clock);
        #1;
        check_all_zero("reset");
        @(negedge i_clock);
        i_reset = 1'b1;

        // acquire lock on lane 5
        send(6 * P, 1);
        chk("train_lock", o_am_lock, 1);
        chk("train_lane", o_lane_id, LANE);

        // three corrupted AMs: one resync, then relock
        tx_bad_am = 3;
        send(7 * P, 1);
        chk("relock_after_bad_am", o_am_lock, 1);
        chk("resync_count_one", o_resync_counter, 1);

        // one payload bit error between AMs
        tx_flip = 1;
        send(2 * P, 1);
        chk("bip_err_count", o_error_counter, 1);
        send(1, 0);
        chk("err_cleared_by_resync", o_error_counter, 0);
        send(4 * P, 1);

        // bip7 check enabled: bad-BIP7 AMs count as bad
        i_rf_bip7_check = 1'b1;
        tx_bad_bip7 = 3;
        send(6 * P, 1);
        chk("bip7_relock", o_am_lock, 1);
        chk("bip7_resyncs", o_resync_counter, 3);

        // bip7 check disabled: same stream stays locked
        i_rf_bip7_check = 1'b0;
        tx_bad_bip7 = 3;
        send(5 * P, 1);
        chk("bip7_off_locked", o_am_lock, 1);

        // disabled window freezes everything
        for (int i = 0; i < 10; i++) beat(0, 1'($urandom), 1'($urandom), {2'($urandom), $urandom, $urandom});
        send(2 * P, 1);

        // two entries identical under the mask: no lock
        tbl[12] = tbl[LANE] ^ 48'h1;
        i_rf_compare_mask = ~48'h1;
        pack_table();
        send(1, 0);
        send(4 * P, 1);
        chk("dup_no_lock", o_am_lock, 0);

        // thresholds 0 behave as 1
        tbl[12] = 48'({$urandom, $urandom});
        i_rf_compare_mask = '1;
        i_rf_valid_am_thr = 5'd0;
        i_rf_invalid_am_thr = 3'd0;
        pack_table();
        send(3 * P, 1);
        chk("thr0_lock", o_am_lock, 1);
        tx_bad_am = 1;
        send(3 * P, 1);

        // asynchronous reset mid-stream
        send(5, 1);
        #2;
        i_reset = 1'b0;
        #1;
        check_all_zero("midreset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
